nios_keys_pio: RTL and testbench

Avalon-MM slave input port that samples external push-buttons and switches for the Nios II processor. It is the read-side counterpart of the LED output port on the same system interconnect. The block synchronises the pins, optionally debounces them, latches selected edges into a software-visible capture register, and raises a maskable level interrupt to the CPU.

---
 rtl/nios_pio_pkg.sv | 15 +
 rtl/nios_keys_pio_if.sv | 15 +
 rtl/nios_keys_debounce.sv | 39 +++
 rtl/nios_keys_pio.sv | 94 +++++++++
 tb/tb_nios_keys_pio.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios PIO blocks: register addresses and edge-select encoding.
package nios_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_e;

endpackage

// File: rtl/nios_keys_pio_if.sv
// Avalon-MM slave register bus for the keys PIO.
// Handshake: a write happens on any clk edge where chipselect=1 and write_n=0; reads have no
// strobe -- readdata is registered and reflects the register at address one edge earlier.
interface nios_keys_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n, output writedata,
                  input readdata);
  modport slave  (input address, input chipselect, input write_n, input writedata,
                  output readdata);
endinterface

// File: rtl/nios_keys_debounce.sv
// Single-bit debouncer: output follows input only after DEBOUNCE_CYCLES consecutive cycles of difference.
module nios_keys_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          f_q, f_d;

  always_comb begin
    cnt_d = '0;
    f_d   = f_q;
    if (din != f_q) begin
      // Terminal count flips the output on the DEBOUNCE_CYCLES-th differing cycle.
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        f_d = din;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      f_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      f_q   <= f_d;
    end
  end

  assign dout = f_q;
endmodule

// File: rtl/nios_keys_pio.sv
// Keys/switches input PIO: sync, optional debounce (NIOS_KEYS_DEBOUNCE_EN), edge capture, masked irq.
module nios_keys_pio
  import nios_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios_keys_pio_if.slave       bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);
  localparam edge_e EDGE_SEL = edge_e'(2'(EDGE_TYPE));

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] w1c;
  logic             wr_en;
  logic             unused_wdata;

`ifdef NIOS_KEYS_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    nios_keys_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sync2_q[i]),
      .dout    (f[i])
    );
  end
`else
  localparam int unused_db_cycles = DEBOUNCE_CYCLES;
  assign f = sync2_q;
`endif

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    sync1_d   = in_port;
    sync2_d   = sync1_q;
    prev_d    = f;
    irqmask_d = irqmask_q;
    w1c       = '0;

    case (EDGE_SEL)
      EDGE_FALLING: edge_det = ~f & prev_q;
      EDGE_ANY:     edge_det = f ^ prev_q;
      default:      edge_det = f & ~prev_q;
    endcase

    if (wr_en && bus.address == PIO_ADDR_IRQMASK) irqmask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == PIO_ADDR_EDGECAP) w1c = bus.writedata[WIDTH-1:0];

    // Edge is OR-ed after the clear so a same-cycle edge survives the W1C.
    edgecap_d = (edgecap_q & ~w1c) | edge_det;

    readdata_d = '0;
    case (bus.address)
      PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = f;
      PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:          readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edgecap_q & irqmask_q);
endmodule

// File: tb/tb_nios_keys_pio.sv
// Directed self-checking bench for nios_keys_pio (WIDTH=4, rising edges, DEBOUNCE_CYCLES=8).
module tb_nios_keys_pio;
`ifdef NIOS_KEYS_DEBOUNCE_EN
  localparam int DBL = 8;
`else
  localparam int DBL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in_port = 4'h0;
  logic       irq;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [31:0] rv;

  nios_keys_pio_if bus();

  nios_keys_pio #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (4 + DBL) tick();
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = data;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [31:0] data);
    bus.address = addr;
    tick();
    data = bus.readdata;
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    in_port = 4'hF;
    reset_n = 1'b0;
    bus.address = 2'd3;
    repeat (3) tick();
    n_tests++;
    if (bus.readdata !== 32'h0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold readdata=%h irq=%b exp 0/0", bus.readdata, irq);
    end
    bus.address = 2'd0;
    reset_n = 1'b1;
    repeat (2 + DBL) tick();
    chk32("reset_data_early", bus.readdata, 32'h0);
    tick();
    chk32("reset_data_f", bus.readdata, 32'hF);
    bus.address = 2'd3;
    tick();
    chk32("reset_edgecap_f", bus.readdata, 32'hF);
    in_port = 4'h0;
    settle();
    wr(2'd3, 32'hFFFF_FFFF);
  endtask

  task automatic test_rising_irq();
    wr(2'd2, 32'h2);
    in_port = 4'b0010;
    repeat (2 + DBL) tick();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_early got=%b exp=0", irq); end
    tick();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL rise_irq got=%b exp=1", irq); end
    rd(2'd3, rv);
    chk32("rise_edgecap", rv, 32'h2);
    wr(2'd3, 32'h2);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_clear got=%b exp=0", irq); end
    rd(2'd3, rv);
    chk32("rise_edgecap_clear", rv, 32'h0);
  endtask

  task automatic test_falling_ignored();
    in_port = 4'h0;
    settle();
    rd(2'd3, rv);
    chk32("fall_no_capture", rv, 32'h0);
  endtask

  task automatic test_clear_edge_race();
    wr(2'd2, 32'h1);
    in_port = 4'h1;
    settle();
    in_port = 4'h0;
    settle();
    in_port = 4'h1;
    repeat (2 + DBL) tick();
    wr(2'd3, 32'h1);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL race_irq got=%b exp=1", irq); end
    rd(2'd3, rv);
    chk32("race_edgecap", rv, 32'h1);
    wr(2'd3, 32'h1);
    rd(2'd3, rv);
    chk32("race_later_clear", rv, 32'h0);
  endtask

  task automatic test_mask_decode();
    in_port = 4'h0;
    settle();
    wr(2'd2, 32'h0);
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    settle();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_zero_irq got=%b exp=0", irq); end
    rd(2'd3, rv);
    chk32("mask_edgecap_f", rv, 32'hF);
    wr(2'd2, 32'hFFFF_FFFF);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_all_irq got=%b exp=1", irq); end
    rd(2'd2, rv);
    chk32("mask_readback", rv, 32'h0000_000F);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, rv);
    chk32("addr1_read", rv, 32'h0);
    wr(2'd0, 32'h0);
    rd(2'd0, rv);
    chk32("data_write_ignored", rv, 32'hF);
    wr(2'd3, 32'h4);
    rd(2'd3, rv);
    chk32("partial_w1c", rv, 32'hB);
  endtask

`ifdef NIOS_KEYS_DEBOUNCE_EN
  task automatic test_debounce_glitch();
    in_port = 4'h0;
    settle();
    wr(2'd3, 32'hF);
    in_port = 4'h4;
    repeat (5) tick();
    in_port = 4'h0;
    repeat (20) tick();
    rd(2'd0, rv);
    chk32("glitch_data", rv, 32'h0);
    rd(2'd3, rv);
    chk32("glitch_edgecap", rv, 32'h0);
  endtask
`endif

  task automatic test_data_latency();
    in_port = 4'h0;
    settle();
    wr(2'd3, 32'hF);
    bus.address = 2'd0;
    in_port = 4'h4;
    repeat (2 + DBL) tick();
    chk32("latency_before", bus.readdata, 32'h0);
    tick();
    chk32("latency_after", bus.readdata, 32'h4);
  endtask

  task automatic test_mid_reset();
    in_port = 4'h0;
    settle();
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h0);
    in_port = 4'h5;
    settle();
    in_port = 4'h0;
    settle();
    rd(2'd3, rv);
    chk32("midrst_pre_edgecap", rv, 32'h5);
    wr(2'd2, 32'h5);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_irq got=%b exp=1", irq); end
    reset_n = 1'b0;
    bus.address = 2'd3;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    bus.writedata = 32'h1;
    tick();
    reset_n = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq got=%b exp=0", irq); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rv);
      chk32($sformatf("midrst_reg%0d", a), rv, 32'h0);
    end
    repeat (10) tick();
    rd(2'd3, rv);
    chk32("midrst_no_spurious", rv, 32'h0);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq_late got=%b exp=0", irq); end
  endtask

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    test_reset();
    test_rising_irq();
    test_falling_ignored();
    test_clear_edge_race();
    test_mask_decode();
`ifdef NIOS_KEYS_DEBOUNCE_EN
    test_debounce_glitch();
`endif
    test_data_latency();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
